// File: rtl/pll_seq_pkg.sv
// Shared state encoding and counter-width helper for the PLL reset sequencer.
// No logic, no latency.
// No flow control; pure declarations.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_WAIT   = 2'd1,
    S_LOCKED = 2'd2,
    S_FAULT  = 2'd3
  } state_e;

  // Bits needed to hold the value max_val itself (never less than 1).
  function automatic int cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pll_chan_seq.sv
// One supervised PLL channel: lock synchroniser, reset hold, debounce/timeout, fault.
// Lock seen LOCK_STABLE+3 edges after raw rise; loss acted on 3 edges after raw fall.
// No backpressure; the loss pulse is a single-cycle combinational strobe.
module pll_chan_seq
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES   = 4,
  parameter int LOCK_STABLE  = 16,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic locked_i,
  input  logic retry_i,
  output logic pll_rst_o,
  output logic locked_o,
  output logic fault_o,
  output logic loss_o
);

  // One counter serves both the reset hold and the lock timeout.
  localparam int TW = cnt_w((RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT);
  localparam int SW = cnt_w(LOCK_STABLE);
  localparam logic [TW-1:0] RST_LAST  = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STAB_DONE = SW'(LOCK_STABLE);

  logic          lk_s1_q, lk_s2_q;
  state_e        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] stab_q, stab_d;

  // Two-flop synchroniser for the raw asynchronous LOCKED input.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lk_s1_q <= 1'b0;
      lk_s2_q <= 1'b0;
    end else begin
      lk_s1_q <= locked_i;
      lk_s2_q <= lk_s1_q;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
      stab_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stab_q  <= stab_d;
    end
  end

  // Next-state and Moore outputs; the stable counter only runs in S_WAIT.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stab_d    = '0;
    pll_rst_o = 1'b0;
    locked_o  = 1'b0;
    fault_o   = 1'b0;
    loss_o    = 1'b0;
    case (state_q)
      S_RESET: begin
        pll_rst_o = 1'b1;
        if (cnt_q == RST_LAST) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (lk_s2_q) begin
          stab_d = (stab_q == STAB_DONE) ? stab_q : stab_q + 1'b1;
        end
        // A completed debounce beats a timeout expiring on the same cycle.
        if (stab_q == STAB_DONE) begin
          state_d = S_LOCKED;
          cnt_d   = '0;
          stab_d  = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_FAULT;
          cnt_d   = '0;
        end
      end
      S_LOCKED: begin
        locked_o = 1'b1;
        if (!lk_s2_q) begin
          state_d = S_RESET;
          cnt_d   = '0;
          loss_o  = 1'b1;
        end
      end
      S_FAULT: begin
        fault_o   = 1'b1;
        pll_rst_o = 1'b1;
        if (retry_i) begin
          state_d = S_RESET;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_RESET;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/pll_reset_seq.sv
// Multi-channel PLL reset sequencer: per-channel supervisors, retry edge, loss counter.
// Retry acts 3 edges after switch rise; O_CNT and O_ALL_LOCKED are registered.
// No backpressure; O_CNT saturates instead of wrapping.
module pll_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int CHANNELS     = 2,
  parameter int RST_CYCLES   = 4,
  parameter int LOCK_STABLE  = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int CNT_WIDTH    = 6
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [CHANNELS-1:0]  I_LOCKED,
  input  logic                 I_RETRY,
  output logic [CHANNELS-1:0]  O_PLL_RST,
  output logic [CHANNELS-1:0]  O_LOCKED,
  output logic                 O_ALL_LOCKED,
  output logic [CHANNELS-1:0]  O_FAULT,
  output logic [CNT_WIDTH-1:0] O_CNT
);

  localparam int PW   = cnt_w(CHANNELS);
  localparam int SUMW = CNT_WIDTH + PW;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                 rt_s1_q, rt_s2_q, rt_s3_q;
  logic                 retry_pulse;
  logic [CHANNELS-1:0]  loss;
  logic [PW-1:0]        loss_cnt;
  logic [SUMW-1:0]      sum;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 all_q;

  // Retry switch: two-flop synchroniser plus one delay flop for rise detection.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rt_s1_q <= 1'b0;
      rt_s2_q <= 1'b0;
      rt_s3_q <= 1'b0;
    end else begin
      rt_s1_q <= I_RETRY;
      rt_s2_q <= rt_s1_q;
      rt_s3_q <= rt_s2_q;
    end
  end

  assign retry_pulse = rt_s2_q & ~rt_s3_q;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    pll_chan_seq #(
      .RST_CYCLES  (RST_CYCLES),
      .LOCK_STABLE (LOCK_STABLE),
      .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) u_chan (
      .clk_i    (CLK),
      .rst_i    (RST),
      .locked_i (I_LOCKED[gi]),
      .retry_i  (retry_pulse),
      .pll_rst_o(O_PLL_RST[gi]),
      .locked_o (O_LOCKED[gi]),
      .fault_o  (O_FAULT[gi]),
      .loss_o   (loss[gi])
    );
  end

  // Population count of this cycle's loss pulses, added to the counter with saturation.
  always_comb begin
    loss_cnt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      loss_cnt = loss_cnt + PW'(loss[i]);
    end
    sum   = SUMW'(cnt_q) + SUMW'(loss_cnt);
    cnt_d = (sum > SUMW'(CNT_MAX)) ? CNT_MAX : sum[CNT_WIDTH-1:0];
  end

  // Loss counter and the one-cycle-late all-locked indicator.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
      all_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      all_q <= &O_LOCKED;
    end
  end

  assign O_CNT        = cnt_q;
  assign O_ALL_LOCKED = all_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq: reset hold, timeout fault, retry, lock, loss, saturation.
// Latencies are counted in edges from the stimulus change.
// No flow control in this block; waits are bounded by cycle budgets.
module tb_pll_reset_seq;

  localparam int CH = 2;
  localparam int RC = 4;
  localparam int LS = 16;
  localparam int LT = 100;
  localparam int CW = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST;
  logic [CH-1:0] I_LOCKED;
  logic          I_RETRY;
  logic [CH-1:0] O_PLL_RST;
  logic [CH-1:0] O_LOCKED;
  logic          O_ALL_LOCKED;
  logic [CH-1:0] O_FAULT;
  logic [CW-1:0] O_CNT;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  int exp_cnt  = 0;
  int events   = 0;

  pll_reset_seq #(
    .CHANNELS    (CH),
    .RST_CYCLES  (RC),
    .LOCK_STABLE (LS),
    .LOCK_TIMEOUT(LT),
    .CNT_WIDTH   (CW)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .I_LOCKED    (I_LOCKED),
    .I_RETRY     (I_RETRY),
    .O_PLL_RST   (O_PLL_RST),
    .O_LOCKED    (O_LOCKED),
    .O_ALL_LOCKED(O_ALL_LOCKED),
    .O_FAULT     (O_FAULT),
    .O_CNT       (O_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic int pop_exp();
    if (exp_q.size() == 0) return -1;
    return exp_q.pop_front();
  endfunction

  task automatic test_reset();
    int n;
    int e;
    RST = 1'b1; I_LOCKED = '0; I_RETRY = 1'b0;
    repeat (3) tick();
    checks++; if (O_PLL_RST !== 2'b11) begin failures++; $display("FAIL rst_pll_rst got=%b want=11", O_PLL_RST); end
    checks++; if (O_LOCKED !== 2'b00) begin failures++; $display("FAIL rst_locked got=%b want=00", O_LOCKED); end
    checks++; if (O_FAULT !== 2'b00) begin failures++; $display("FAIL rst_fault got=%b want=00", O_FAULT); end
    checks++; if (O_ALL_LOCKED !== 1'b0) begin failures++; $display("FAIL rst_all_locked got=%b want=0", O_ALL_LOCKED); end
    checks++; if (O_CNT !== '0) begin failures++; $display("FAIL rst_cnt got=%0d want=0", O_CNT); end
    exp_q.push_back(RC);
    RST = 1'b0;
    n = 0;
    do begin tick(); n++; end while (O_PLL_RST !== '0 && n < 50);
    e = pop_exp();
    checks++; if (n !== e) begin failures++; $display("FAIL rst_hold_edges got=%0d want=%0d", n, e); end
    exp_q.push_back(LT);
    n = 0;
    do begin tick(); n++; end while (O_FAULT !== '1 && n < LT + 50);
    e = pop_exp();
    checks++; if (n !== e) begin failures++; $display("FAIL timeout_edges got=%0d want=%0d", n, e); end
    checks++; if (O_PLL_RST !== 2'b11) begin failures++; $display("FAIL fault_pll_rst got=%b want=11", O_PLL_RST); end
    checks++; if (O_LOCKED !== 2'b00) begin failures++; $display("FAIL fault_locked got=%b want=00", O_LOCKED); end
  endtask

  task automatic test_retry();
    int n;
    int e;
    exp_q.push_back(3);
    I_RETRY = 1'b1;
    n = 0;
    do begin tick(); n++; end while (O_FAULT !== '0 && n < 20);
    e = pop_exp();
    checks++; if (n !== e) begin failures++; $display("FAIL retry_edges got=%0d want=%0d", n, e); end
    checks++; if (O_PLL_RST !== 2'b11) begin failures++; $display("FAIL retry_pll_rst got=%b want=11", O_PLL_RST); end
    exp_q.push_back(RC);
    n = 0;
    do begin tick(); n++; end while (O_PLL_RST !== '0 && n < 50);
    e = pop_exp();
    checks++; if (n !== e) begin failures++; $display("FAIL retry_hold_edges got=%0d want=%0d", n, e); end
    I_RETRY = 1'b0;
  endtask

  task automatic test_lock();
    int n;
    int e;
    repeat (10) tick();
    exp_q.push_back(LS + 3);
    I_LOCKED[0] = 1'b1;
    n = 0;
    do begin tick(); n++; end while (O_LOCKED[0] !== 1'b1 && n < 100);
    e = pop_exp();
    checks++; if (n !== e) begin failures++; $display("FAIL lock0_edges got=%0d want=%0d", n, e); end
    checks++; if (O_ALL_LOCKED !== 1'b0) begin failures++; $display("FAIL all_locked_one got=%b want=0", O_ALL_LOCKED); end
    exp_q.push_back(LS + 3);
    I_LOCKED[1] = 1'b1;
    n = 0;
    do begin tick(); n++; end while (O_LOCKED[1] !== 1'b1 && n < 100);
    e = pop_exp();
    checks++; if (n !== e) begin failures++; $display("FAIL lock1_edges got=%0d want=%0d", n, e); end
    checks++; if (O_ALL_LOCKED !== 1'b0) begin failures++; $display("FAIL all_locked_lag got=%b want=0", O_ALL_LOCKED); end
    tick();
    checks++; if (O_ALL_LOCKED !== 1'b1) begin failures++; $display("FAIL all_locked_set got=%b want=1", O_ALL_LOCKED); end
    // Retry while nothing is faulted must not disturb locked channels.
    I_RETRY = 1'b1;
    repeat (6) tick();
    checks++; if (O_LOCKED !== 2'b11) begin failures++; $display("FAIL retry_ignored_locked got=%b want=11", O_LOCKED); end
    checks++; if (O_PLL_RST !== 2'b00) begin failures++; $display("FAIL retry_ignored_pll_rst got=%b want=00", O_PLL_RST); end
    I_RETRY = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_back_to_back();
    int n;
    int e;
    logic al1;
    exp_q.push_back(3);
    I_LOCKED = '0;
    exp_cnt = exp_cnt + 2;
    events  = events + 2;
    n = 0;
    do begin tick(); n++; end while (O_LOCKED !== '0 && n < 20);
    e = pop_exp();
    checks++; if (n !== e) begin failures++; $display("FAIL dual_loss_edges got=%0d want=%0d", n, e); end
    checks++; if (O_PLL_RST !== 2'b11) begin failures++; $display("FAIL dual_loss_pll_rst got=%b want=11", O_PLL_RST); end
    checks++; if (O_CNT !== CW'(exp_cnt)) begin failures++; $display("FAIL dual_loss_cnt got=%0d want=%0d", O_CNT, exp_cnt); end
    checks++; if (O_ALL_LOCKED !== 1'b1) begin failures++; $display("FAIL dual_loss_all_lag got=%b want=1", O_ALL_LOCKED); end
    exp_q.push_back(RC + LS + 1);
    I_LOCKED = '1;
    n = 0;
    al1 = 1'bx;
    do begin
      tick(); n++;
      if (n == 1) al1 = O_ALL_LOCKED;
    end while (O_LOCKED !== '1 && n < 100);
    e = pop_exp();
    checks++; if (al1 !== 1'b0) begin failures++; $display("FAIL dual_loss_all_clear got=%b want=0", al1); end
    checks++; if (n !== e) begin failures++; $display("FAIL relock_edges got=%0d want=%0d", n, e); end
    tick();
  endtask

  task automatic test_glitch();
    int n;
    int e;
    exp_q.push_back(3);
    I_LOCKED[0] = 1'b0;
    exp_cnt = exp_cnt + 1;
    events  = events + 1;
    n = 0;
    do begin tick(); n++; end while (O_LOCKED[0] !== 1'b0 && n < 20);
    e = pop_exp();
    checks++; if (n !== e) begin failures++; $display("FAIL loss0_edges got=%0d want=%0d", n, e); end
    checks++; if (O_PLL_RST !== 2'b01) begin failures++; $display("FAIL loss0_pll_rst got=%b want=01", O_PLL_RST); end
    checks++; if (O_CNT !== CW'(exp_cnt)) begin failures++; $display("FAIL loss0_cnt got=%0d want=%0d", O_CNT, exp_cnt); end
    checks++; if (O_LOCKED[1] !== 1'b1) begin failures++; $display("FAIL loss0_ch1_kept got=%b want=1", O_LOCKED[1]); end
    exp_q.push_back(RC);
    n = 0;
    do begin tick(); n++; end while (O_PLL_RST[0] !== 1'b0 && n < 50);
    e = pop_exp();
    checks++; if (n !== e) begin failures++; $display("FAIL loss0_hold_edges got=%0d want=%0d", n, e); end
    repeat (3) tick();
    I_LOCKED[0] = 1'b1;
    repeat (8) tick();
    I_LOCKED[0] = 1'b0;
    tick();
    exp_q.push_back(LS + 3);
    I_LOCKED[0] = 1'b1;
    n = 0;
    do begin tick(); n++; end while (O_LOCKED[0] !== 1'b1 && n < 100);
    e = pop_exp();
    checks++; if (n !== e) begin failures++; $display("FAIL glitch_relock_edges got=%0d want=%0d", n, e); end
    checks++; if (O_LOCKED[1] !== 1'b1) begin failures++; $display("FAIL glitch_ch1_kept got=%b want=1", O_LOCKED[1]); end
    checks++; if (O_CNT !== CW'(exp_cnt)) begin failures++; $display("FAIL glitch_cnt got=%0d want=%0d", O_CNT, exp_cnt); end
  endtask

  task automatic test_saturate();
    int n;
    int e;
    while (events < 70) begin
      exp_q.push_back(3);
      I_LOCKED = '0;
      events  = events + 2;
      exp_cnt = (exp_cnt + 2 > CMAX) ? CMAX : exp_cnt + 2;
      n = 0;
      do begin tick(); n++; end while (O_LOCKED !== '0 && n < 20);
      e = pop_exp();
      checks++; if (n !== e) begin failures++; $display("FAIL sat_loss_edges ev=%0d got=%0d want=%0d", events, n, e); end
      checks++; if (O_CNT !== CW'(exp_cnt)) begin failures++; $display("FAIL sat_cnt ev=%0d got=%0d want=%0d", events, O_CNT, exp_cnt); end
      I_LOCKED = '1;
      n = 0;
      do begin tick(); n++; end while (O_LOCKED !== '1 && n < 100);
      checks++; if (n !== RC + LS + 1) begin failures++; $display("FAIL sat_relock ev=%0d got=%0d want=%0d", events, n, RC + LS + 1); end
    end
    checks++; if (O_CNT !== CW'(CMAX)) begin failures++; $display("FAIL sat_final got=%0d want=%0d", O_CNT, CMAX); end
  endtask

  task automatic test_rst_mid();
    int n;
    int e;
    I_LOCKED[1] = 1'b0;
    n = 0;
    do begin tick(); n++; end while (O_PLL_RST[1] !== 1'b1 && n < 20);
    n = 0;
    do begin tick(); n++; end while (O_PLL_RST[1] !== 1'b0 && n < 20);
    repeat (2) tick();
    checks++; if (O_LOCKED[0] !== 1'b1) begin failures++; $display("FAIL mid_ch0_kept got=%b want=1", O_LOCKED[0]); end
    #2;
    RST = 1'b1;
    #1;
    checks++; if (O_PLL_RST !== 2'b11) begin failures++; $display("FAIL mid_pll_rst got=%b want=11", O_PLL_RST); end
    checks++; if (O_LOCKED !== 2'b00) begin failures++; $display("FAIL mid_locked got=%b want=00", O_LOCKED); end
    checks++; if (O_CNT !== '0) begin failures++; $display("FAIL mid_cnt got=%0d want=0", O_CNT); end
    checks++; if (O_FAULT !== 2'b00) begin failures++; $display("FAIL mid_fault got=%b want=00", O_FAULT); end
    checks++; if (O_ALL_LOCKED !== 1'b0) begin failures++; $display("FAIL mid_all_locked got=%b want=0", O_ALL_LOCKED); end
    tick();
    exp_q.push_back(RC);
    RST = 1'b0;
    n = 0;
    do begin tick(); n++; end while (O_PLL_RST !== '0 && n < 50);
    e = pop_exp();
    checks++; if (n !== e) begin failures++; $display("FAIL mid_rehold_edges got=%0d want=%0d", n, e); end
  endtask

  initial begin
    test_reset();
    test_retry();
    test_lock();
    test_back_to_back();
    test_glitch();
    test_saturate();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pll_reset_seq.md
# pll_reset_seq

Parametrised, multi-channel PLL reset sequencer and lock supervisor for the PLLE2/MMCME2 minitest tops. It replaces the fixed shift-register reset and single lock LED with one supervised channel per PLL. Each channel does the following:
- holds its PLL in reset for a programmable time;
- waits, with a timeout, for a debounced lock;
- reports a fault if lock never arrives;
- re-sequences automatically when lock is lost.

It sits between the board clock/reset and the PLL test instances, and drives the LED status outputs.

## Interface
Parameters:
- CHANNELS, 2: number of supervised PLLs (1..8).
- RST_CYCLES, 4: cycles O_PLL_RST is held high per sequence (>=1).
- LOCK_STABLE, 16: consecutive synchronised-lock cycles required before a channel is declared locked (>=1).
- LOCK_TIMEOUT, 4096: maximum cycles spent waiting for lock before a fault is declared (> LOCK_STABLE).
- CNT_WIDTH, 6: width of the lock-loss event counter.

Ports:
- CLK  in  1  single system clock; all logic is on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- I_LOCKED  in  CHANNELS  raw PLL LOCKED outputs; asynchronous, each passes through a 2-flop synchroniser.
- I_RETRY  in  1  asynchronous retry request (switch); 2-flop synchronised, then rising-edge detected.
- O_PLL_RST  out  CHANNELS  per-channel PLL reset, active-high.
- O_LOCKED  out  CHANNELS  per-channel supervised lock.
- O_ALL_LOCKED  out  1  AND of O_LOCKED, registered.
- O_FAULT  out  CHANNELS  per-channel lock-timeout fault.
- O_CNT  out  CNT_WIDTH  total lock-loss events across all channels, saturating.

## Operation
- Reset values, applied while RST is high:
  - O_PLL_RST = all ones.
  - O_LOCKED, O_FAULT, O_ALL_LOCKED, O_CNT = 0.
  - Synchronisers and edge detector cleared.
  - Every channel in S_RESET with its counter at 0.
- Per-channel FSM states:
  - S_RESET:
    - O_PLL_RST=1.
    - Counts RST_CYCLES cycles, then goes to S_WAIT.
  - S_WAIT:
    - O_PLL_RST=0. Timeout counter and stable counter both run.
    - Synchronised lock low clears the stable counter.
    - Stable counter reaching LOCK_STABLE goes to S_LOCKED.
    - Otherwise, timeout counter reaching LOCK_TIMEOUT goes to S_FAULT.
    - If both complete in the same cycle, S_LOCKED wins.
  - S_LOCKED:
    - O_LOCKED=1.
    - Synchronised lock low for one cycle: go to S_RESET and emit one loss event.
  - S_FAULT:
    - O_FAULT=1, O_PLL_RST=1.
    - A retry edge goes to S_RESET and clears O_FAULT. The retry edge is ignored in all other states.
- O_CNT:
  - Adds the number of loss events in each cycle. Simultaneous losses on k channels add k.
  - Saturates at 2^CNT_WIDTH-1 and never wraps.
  - Cleared only by RST.
- A retry edge resets every faulted channel simultaneously.
- Channels are fully independent. A loss on one channel never disturbs another.

## Timing
- O_PLL_RST rises asynchronously when RST asserts. After RST deasserts, it stays high for exactly RST_CYCLES edges.
- Lock detection latency:
  - 2 cycles of synchroniser, plus LOCK_STABLE cycles.
  - O_LOCKED rises on the edge after the stable count completes.
  - Total from the I_LOCKED rising edge: LOCK_STABLE+3 edges.
- Lock-loss latency:
  - O_LOCKED falls and O_PLL_RST rises 3 edges after I_LOCKED falls.
  - O_CNT updates on the same edge.
- O_ALL_LOCKED lags the O_LOCKED AND by one cycle.
- Retry latency: from an I_RETRY rising edge to O_PLL_RST re-entering the S_RESET hold is 3 edges (2 sync + 1 edge detect).
- RST mid-operation: all state is abandoned immediately and asynchronously. No partial sequence resumes.

## Structure
- Shared package pll_seq_pkg holds:
  - state encoding constants S_RESET, S_WAIT, S_LOCKED, S_FAULT (2 bits);
  - a $clog2-based counter width helper.
- Sub-module pll_chan_seq: one channel's synchroniser, counters and FSM. It outputs pll_rst, locked, fault and a loss pulse. Instantiated CHANNELS times in a generate loop.
- The top level holds the retry synchroniser/edge detector, the loss-pulse population count into saturating O_CNT, and the O_ALL_LOCKED register.

## Test plan
- Release RST with I_LOCKED=0, RST_CYCLES=4 → O_PLL_RST high for 4 edges, then low. O_FAULT rises after LOCK_TIMEOUT cycles in S_WAIT. O_LOCKED stays 0.
- Raise I_LOCKED[0] 10 cycles after O_PLL_RST falls, with LOCK_STABLE=16 → O_LOCKED[0] rises 19 edges later. O_ALL_LOCKED follows 1 cycle after the last channel locks.
- Glitch I_LOCKED[0] low for 1 cycle mid-debounce → stable count restarts. O_LOCKED is delayed by the full LOCK_STABLE again.
- Drop I_LOCKED[0] and I_LOCKED[1] on the same cycle while both are locked → both re-enter S_RESET after 3 edges, and O_CNT goes 0→2.
- Force 70 loss events with CNT_WIDTH=6 → O_CNT saturates at 63.
- Faulted channel, then pulse I_RETRY → new RST_CYCLES reset after 3 edges and O_FAULT clears. Assert RST mid-S_WAIT → all outputs return to reset values immediately.
